wb_pipe_reg: RTL and testbench

Parametrised, elastic successor to the MEM/WB pipeline register. Carries write-back payload (memory read data, ALU result, destination register, RegWrite/MemToReg) through `STAGES` registered slots, with valid/ready handshaking, bubble collapsing and synchronous flush. It sits between the MEM stage and the register-file write port, so a stalled write-back no longer silently drops or overwrites results.

---
 rtl/wb_pipe_reg.sv | 147 ++++++++++++++
 tb/tb_wb_pipe_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// Elastic MEM/WB pipeline register: STAGES valid/ready slots with bubble collapsing and flush.
// Optional hazard-unit forwarding ports are enabled by defining WB_PIPE_FWD_EN.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = ($clog2(STAGES + 1) < 1) ? 1 : $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] RDData_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] RDData_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [CNT_W-1:0]  occupancy_o
`ifdef WB_PIPE_FWD_EN
  ,
  output logic [STAGES-1:0]        fwd_valid_o,
  output logic [STAGES*ADDR_W-1:0] fwd_addr_o,
  output logic [STAGES*DATA_W-1:0] fwd_data_o
`endif
);

  // Handshake: an entry transfers on a rising edge where valid and ready are both 1;
  // ready never depends on valid from the same side, in_ready_o is the only combinational output.

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] adv;
  logic [DATA_W-1:0] rd_data_q [STAGES];
  logic [DATA_W-1:0] rd_data_d [STAGES];
  logic [DATA_W-1:0] alu_q     [STAGES];
  logic [DATA_W-1:0] alu_d     [STAGES];
  logic [ADDR_W-1:0] rd_addr_q [STAGES];
  logic [ADDR_W-1:0] rd_addr_d [STAGES];
  logic [STAGES-1:0] reg_write_q, reg_write_d;
  logic [STAGES-1:0] mem_to_reg_q, mem_to_reg_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              accept;
  logic              chain;

  // Advance chain walks from the output slot back toward slot 0.
  always_comb begin
    adv   = '0;
    chain = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = chain;
      chain  = !valid_q[k] || chain;
    end
  end

  assign in_ready_o = !rst_i && !flush_i && (!valid_q[0] || adv[0]);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    valid_d      = valid_q;
    rd_data_d    = rd_data_q;
    alu_d        = alu_q;
    rd_addr_d    = rd_addr_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    occ_d        = '0;

    if (accept) begin
      valid_d[0]      = 1'b1;
      rd_data_d[0]    = RDData_i;
      alu_d[0]        = ALUResult_i;
      rd_addr_d[0]    = RDaddr_i;
      reg_write_d[0]  = RegWrite_i;
      mem_to_reg_d[0] = MemToReg_i;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (valid_q[k-1] && adv[k-1] && !flush_i) begin
        valid_d[k]      = 1'b1;
        rd_data_d[k]    = rd_data_q[k-1];
        alu_d[k]        = alu_q[k-1];
        rd_addr_d[k]    = rd_addr_q[k-1];
        reg_write_d[k]  = reg_write_q[k-1];
        mem_to_reg_d[k] = mem_to_reg_q[k-1];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    // Flush drops every entry but leaves payload registers untouched.
    if (flush_i) valid_d = '0;

    for (int k = 0; k < STAGES; k++) occ_d = occ_d + CNT_W'(valid_d[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      reg_write_q  <= '0;
      mem_to_reg_q <= '0;
      occ_q        <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_data_q[k] <= '0;
        alu_q[k]     <= '0;
        rd_addr_q[k] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      occ_q        <= occ_d;
      rd_data_q    <= rd_data_d;
      alu_q        <= alu_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign out_valid_o = valid_q[STAGES-1];
  assign RDData_o    = rd_data_q[STAGES-1];
  assign ALUResult_o = alu_q[STAGES-1];
  assign RDaddr_o    = rd_addr_q[STAGES-1];
  assign RegWrite_o  = reg_write_q[STAGES-1] && valid_q[STAGES-1];
  assign MemToReg_o  = mem_to_reg_q[STAGES-1];
  assign occupancy_o = occ_q;

`ifdef WB_PIPE_FWD_EN
  always_comb begin
    fwd_valid_o = '0;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    for (int k = 0; k < STAGES; k++) begin
      fwd_valid_o[k]               = valid_q[k] && reg_write_q[k] && (rd_addr_q[k] != '0);
      fwd_addr_o[k*ADDR_W +: ADDR_W] = rd_addr_q[k];
      fwd_data_o[k*DATA_W +: DATA_W] = mem_to_reg_q[k] ? rd_data_q[k] : alu_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: a STAGES=2 instance (a_*) and a STAGES=3 instance (b_*).
// Forwarding checks are compiled only when WB_PIPE_FWD_EN is defined.
module tb_wb_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // STAGES=2 instance signals
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_rd_data, a_alu, a_rd_data_o, a_alu_o;
  logic [4:0]  a_rd_addr, a_rd_addr_o;
  logic        a_reg_write, a_mem_to_reg, a_reg_write_o, a_mem_to_reg_o;
  logic [1:0]  a_occ;
  // STAGES=3 instance signals
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_rd_data, b_alu, b_rd_data_o, b_alu_o;
  logic [4:0]  b_rd_addr, b_rd_addr_o;
  logic        b_reg_write, b_mem_to_reg, b_reg_write_o, b_mem_to_reg_o;
  logic [1:0]  b_occ;
`ifdef WB_PIPE_FWD_EN
  logic [1:0]  a_fwd_valid;
  logic [9:0]  a_fwd_addr;
  logic [63:0] a_fwd_data;
  logic [2:0]  b_fwd_valid;
  logic [14:0] b_fwd_addr;
  logic [95:0] b_fwd_data;
`endif

  wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .STAGES(2)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .RDData_i(a_rd_data), .ALUResult_i(a_alu), .RDaddr_i(a_rd_addr),
    .RegWrite_i(a_reg_write), .MemToReg_i(a_mem_to_reg),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .RDData_o(a_rd_data_o), .ALUResult_o(a_alu_o), .RDaddr_o(a_rd_addr_o),
    .RegWrite_o(a_reg_write_o), .MemToReg_o(a_mem_to_reg_o),
    .occupancy_o(a_occ)
`ifdef WB_PIPE_FWD_EN
    , .fwd_valid_o(a_fwd_valid), .fwd_addr_o(a_fwd_addr), .fwd_data_o(a_fwd_data)
`endif
  );

  wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .STAGES(3)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .RDData_i(b_rd_data), .ALUResult_i(b_alu), .RDaddr_i(b_rd_addr),
    .RegWrite_i(b_reg_write), .MemToReg_i(b_mem_to_reg),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .RDData_o(b_rd_data_o), .ALUResult_o(b_alu_o), .RDaddr_o(b_rd_addr_o),
    .RegWrite_o(b_reg_write_o), .MemToReg_o(b_mem_to_reg_o),
    .occupancy_o(b_occ)
`ifdef WB_PIPE_FWD_EN
    , .fwd_valid_o(b_fwd_valid), .fwd_addr_o(b_fwd_addr), .fwd_data_o(b_fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] addr, input logic rw, input logic m2r);
    a_in_valid = v; a_alu = alu; a_rd_data = rd; a_rd_addr = addr;
    a_reg_write = rw; a_mem_to_reg = m2r;
  endtask

  task automatic drv_b(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] addr, input logic rw, input logic m2r);
    b_in_valid = v; b_alu = alu; b_rd_data = rd; b_rd_addr = addr;
    b_reg_write = rw; b_mem_to_reg = m2r;
  endtask

  initial begin
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_out_ready = 1'b0;
    drv_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    drv_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // ---- reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      step();
      drv_a(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      a_out_ready = 1'($urandom_range(0, 1));
      settle();
      chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      chk("rst_occ", {30'd0, a_occ}, 32'd0);
      chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("rst_regwrite", {31'd0, a_reg_write_o}, 32'd0);
      chk("rst_memtoreg", {31'd0, a_mem_to_reg_o}, 32'd0);
      chk("rst_alu", a_alu_o, 32'd0);
      chk("rst_rddata", a_rd_data_o, 32'd0);
      chk("rst_rdaddr", {27'd0, a_rd_addr_o}, 32'd0);
    end
    step();
    rst = 1'b0;
    drv_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    a_out_ready = 1'b0;
    settle();
    chk("rel_in_ready_a", {31'd0, a_in_ready}, 32'd1);
    chk("rel_in_ready_b", {31'd0, b_in_ready}, 32'd1);
    chk("rel_occ_a", {30'd0, a_occ}, 32'd0);

    // ---- streaming on STAGES=3: ALUResult 1..10 back-to-back, visible 3 steps after drive
    b_out_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      step();
      if (s < 10) drv_b(1'b1, 32'(s + 1), 32'h0, 5'(s + 1), 1'b1, 1'b0);
      else        drv_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      settle();
      if (s < 10) chk("stream_in_ready", {31'd0, b_in_ready}, 32'd1);
      if (b_in_valid && b_in_ready) exp_q.push_back(32'(s + 1));
      chk("stream_out_valid", {31'd0, b_out_valid}, {31'd0, (s >= 3 && s <= 12)});
      chk("stream_regwrite", {31'd0, b_reg_write_o}, {31'd0, (s >= 3 && s <= 12)});
      if (b_out_valid) begin
        if (exp_q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("stream_alu", b_alu_o, e);
          chk("stream_rdaddr", {27'd0, b_rd_addr_o}, {27'd0, e[4:0]});
        end
      end
    end
    chk("stream_drain", exp_q.size(), 32'd0);

    // ---- backpressure on STAGES=2
    step(); drv_a(1'b1, 32'h11, 32'h0, 5'd1, 1'b1, 1'b0); settle();
    chk("bp_ready_a", {31'd0, a_in_ready}, 32'd1);
    step(); drv_a(1'b1, 32'h22, 32'h0, 5'd2, 1'b1, 1'b0); settle();
    chk("bp_occ1", {30'd0, a_occ}, 32'd1);
    chk("bp_ready_b", {31'd0, a_in_ready}, 32'd1);
    step(); drv_a(1'b1, 32'h33, 32'h0, 5'd3, 1'b1, 1'b0); settle();
    chk("bp_occ2", {30'd0, a_occ}, 32'd2);
    chk("bp_ready_c", {31'd0, a_in_ready}, 32'd0);
    chk("bp_head_a", a_alu_o, 32'h11);
    step(); settle();
    chk("bp_hold_occ", {30'd0, a_occ}, 32'd2);
    chk("bp_hold_head", a_alu_o, 32'h11);
    chk("bp_hold_ready", {31'd0, a_in_ready}, 32'd0);
    step(); a_out_ready = 1'b1; settle();
    chk("bp_reopen", {31'd0, a_in_ready}, 32'd1);
    step(); drv_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); settle();
    chk("bp_out_b", a_alu_o, 32'h22);
    chk("bp_occ_b", {30'd0, a_occ}, 32'd2);
    step(); settle();
    chk("bp_out_c", a_alu_o, 32'h33);
    chk("bp_occ_c", {30'd0, a_occ}, 32'd1);
    step(); settle();
    chk("bp_empty", {31'd0, a_out_valid}, 32'd0);
    chk("bp_empty_rw", {31'd0, a_reg_write_o}, 32'd0);

    // ---- bubble collapse and full accept+consume on STAGES=3
    b_out_ready = 1'b0;
    step(); drv_b(1'b1, 32'h5, 32'h0, 5'd5, 1'b1, 1'b0); settle();
    step(); drv_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); settle();
    chk("bub_occ1", {30'd0, b_occ}, 32'd1);
    chk("bub_not_out", {31'd0, b_out_valid}, 32'd0);
    step(); settle();
    chk("bub_not_out2", {31'd0, b_out_valid}, 32'd0);
    step(); drv_b(1'b1, 32'h6, 32'h0, 5'd6, 1'b1, 1'b0); settle();
    chk("bub_at_slot2", {31'd0, b_out_valid}, 32'd1);
    chk("bub_head", b_alu_o, 32'h5);
    chk("bub_occ_head", {30'd0, b_occ}, 32'd1);
    step(); drv_b(1'b1, 32'h7, 32'h0, 5'd7, 1'b1, 1'b0); settle();
    chk("bub_ready7", {31'd0, b_in_ready}, 32'd1);
    step(); drv_b(1'b1, 32'h8, 32'h0, 5'd8, 1'b1, 1'b0); settle();
    chk("bub_full_occ", {30'd0, b_occ}, 32'd3);
    chk("bub_full_ready", {31'd0, b_in_ready}, 32'd0);
    b_out_ready = 1'b1; settle();
    chk("bub_full_reopen", {31'd0, b_in_ready}, 32'd1);
    step(); drv_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); settle();
    chk("full_swap_occ", {30'd0, b_occ}, 32'd3);
    chk("full_swap_out6", b_alu_o, 32'h6);
    step(); settle();
    chk("drain_out7", b_alu_o, 32'h7);
    chk("drain_occ2", {30'd0, b_occ}, 32'd2);
    step(); settle();
    chk("drain_out8", b_alu_o, 32'h8);
    step(); settle();
    chk("drain_empty", {31'd0, b_out_valid}, 32'd0);
    chk("drain_occ0", {30'd0, b_occ}, 32'd0);

    // ---- flush on STAGES=2 with occupancy 2 and a valid input in the flush cycle
    a_out_ready = 1'b0;
    step(); drv_a(1'b1, 32'h44, 32'h0, 5'd4, 1'b1, 1'b1); settle();
    step(); drv_a(1'b1, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0); settle();
    step(); drv_a(1'b1, 32'h66, 32'h0, 5'd6, 1'b1, 1'b0); a_flush = 1'b1; settle();
    chk("fl_pre_occ", {30'd0, a_occ}, 32'd2);
    chk("fl_ready", {31'd0, a_in_ready}, 32'd0);
    step(); a_flush = 1'b0; drv_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); settle();
    chk("fl_occ", {30'd0, a_occ}, 32'd0);
    chk("fl_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("fl_regwrite", {31'd0, a_reg_write_o}, 32'd0);
    chk("fl_stale_alu", a_alu_o, 32'h44);
    chk("fl_stale_m2r", {31'd0, a_mem_to_reg_o}, 32'd1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      chk("fl_no_leak", {31'd0, a_out_valid}, 32'd0);
    end

`ifdef WB_PIPE_FWD_EN
    // ---- forwarding: addr 0 slot masked, addr 7 MemToReg slot forwards RDData
    b_out_ready = 1'b0;
    step(); drv_b(1'b1, 32'h1234, 32'hBEEF, 5'd0, 1'b1, 1'b0); settle();
    step(); drv_b(1'b1, 32'h5678, 32'hDEAD, 5'd7, 1'b1, 1'b1); settle();
    step(); drv_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0); settle();
    chk("fwd_valid_addr0", {31'd0, b_fwd_valid[1]}, 32'd0);
    chk("fwd_valid_slot0", {31'd0, b_fwd_valid[0]}, 32'd1);
    chk("fwd_data_slot0", b_fwd_data[31:0], 32'hDEAD);
    chk("fwd_addr_slot0", {27'd0, b_fwd_addr[4:0]}, 32'd7);
    chk("fwd_data_slot1", b_fwd_data[63:32], 32'h1234);
    b_flush = 1'b1;
    step(); b_flush = 1'b0; settle();
    chk("fwd_flushed", {29'd0, b_fwd_valid}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
